// File: rtl/pe_req_collector_if.sv
// Request/grant bundle between the request collector, its stimulus source and priority_enc.
// The master side drives raw requests and encoder feedback; the slave side is the collector.
interface pe_req_collector_if;
  logic [3:0] req_in;
  logic [1:0] Y;
  logic       valid;
  logic       ack;
  logic [3:0] D;
  logic [3:0] pending;
  logic [3:0] overflow;
  logic       boost;

  modport master (
    output req_in, Y, valid, ack,
    input  D, pending, overflow, boost
  );

  modport slave (
    input  req_in, Y, valid, ack,
    output D, pending, overflow, boost
  );
endinterface

// File: rtl/pe_req_collector.sv
// Edge-detecting sticky request collector feeding priority_enc, with per-line age counters.
// Define PE_AGE_BOOST_EN to let a starved (age-saturated) line override D as a one-hot grant.
module pe_req_collector #(
  parameter int AGE_MAX = 15,
  parameter int AGE_W   = $clog2(AGE_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  pe_req_collector_if.slave bus
);

  typedef enum logic {NORMAL, BOOST} mode_t;

  localparam logic [AGE_W-1:0] AGE_SAT = AGE_W'(AGE_MAX);

  logic [3:0]       r_req_prev;
  logic [3:0]       r_pending;
  logic [3:0]       r_overflow;
  logic [3:0]       r_D;
  mode_t            r_mode;
  logic [AGE_W-1:0] r_age [4];

  logic [3:0]       w_rise;
  logic [3:0]       w_clr;
  logic [3:0]       w_pend_nxt;
  logic [3:0]       w_D_nxt;
  logic [1:0]       w_gidx;
  mode_t            w_mode_nxt;
  logic [AGE_W-1:0] w_age_nxt [4];

  // Encoder index 00 names bit 3, so the granted line is the bitwise inverse of Y.
  assign w_gidx = ~bus.Y;

  always_comb begin
    w_rise = bus.req_in & ~r_req_prev;
    w_clr  = '0;
    if (bus.ack && bus.valid)
      w_clr[w_gidx] = r_pending[w_gidx];
    w_pend_nxt = w_rise | (r_pending & ~w_clr);

    for (int i = 0; i < 4; i++) begin
      if (!w_pend_nxt[i] || w_clr[i])
        w_age_nxt[i] = '0;
      else if (r_age[i] == AGE_SAT)
        w_age_nxt[i] = r_age[i];
      else
        w_age_nxt[i] = r_age[i] + AGE_W'(1);
    end

    w_D_nxt    = w_pend_nxt;
    w_mode_nxt = NORMAL;
`ifdef PE_AGE_BOOST_EN
    // Scan high to low so the lowest-index saturated line ends up owning D.
    for (int i = 3; i >= 0; i--) begin
      if (w_pend_nxt[i] && (w_age_nxt[i] == AGE_SAT)) begin
        w_D_nxt    = 4'b0001 << i;
        w_mode_nxt = BOOST;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_prev <= bus.req_in;
      r_pending  <= '0;
      r_overflow <= '0;
      r_D        <= '0;
      r_mode     <= NORMAL;
      for (int i = 0; i < 4; i++)
        r_age[i] <= '0;
    end else begin
      r_req_prev <= bus.req_in;
      r_pending  <= w_pend_nxt;
      r_overflow <= r_overflow | (w_rise & r_pending & ~w_clr);
      r_D        <= w_D_nxt;
      r_mode     <= w_mode_nxt;
      for (int i = 0; i < 4; i++)
        r_age[i] <= w_age_nxt[i];
    end
  end

  assign bus.D        = r_D;
  assign bus.pending  = r_pending;
  assign bus.overflow = r_overflow;
  assign bus.boost    = (r_mode == BOOST);

endmodule

// File: tb/tb_pe_req_collector.sv
// Randomised and directed bench for pe_req_collector against a per-line behavioural model.
// Build with or without PE_AGE_BOOST_EN; expectations follow the same macro.
module tb_pe_req_collector;

  localparam int AGE_MAX = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  pe_req_collector_if bus ();

  pe_req_collector #(.AGE_MAX(AGE_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: one record per request line.
  bit [3:0] m_pend;
  bit [3:0] m_ovf;
  bit [3:0] m_prev;
  bit [3:0] m_D;
  bit       m_boost;
  int       m_age [4];

  task automatic model_step(input bit r, input bit [3:0] req, input bit [1:0] y,
                            input bit v, input bit a);
    bit rise;
    bit clr;
    bit np;
    int granted;
    granted = 3 - int'(y);
    if (r) begin
      m_pend = '0;
      m_ovf  = '0;
      for (int i = 0; i < 4; i++) m_age[i] = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        rise = req[i] && !m_prev[i];
        clr  = a && v && (granted == i) && m_pend[i];
        if (rise && m_pend[i] && !clr) m_ovf[i] = 1'b1;
        np = rise || (m_pend[i] && !clr);
        if (!np || clr) m_age[i] = 0;
        else if (m_age[i] < AGE_MAX) m_age[i] = m_age[i] + 1;
        m_pend[i] = np;
      end
    end
    m_prev  = req;
    m_D     = m_pend;
    m_boost = 1'b0;
`ifdef PE_AGE_BOOST_EN
    if (!r) begin
      for (int i = 0; i < 4; i++) begin
        if (!m_boost && m_pend[i] && m_age[i] == AGE_MAX) begin
          m_D     = 4'b0001 << i;
          m_boost = 1'b1;
        end
      end
    end
`endif
  endtask

  // Apply one cycle of inputs, advance the model and the DUT, then settle past the edge.
  task automatic cycle(input bit r, input bit [3:0] req, input bit [1:0] y,
                       input bit v, input bit a);
    rst        = r;
    bus.req_in = req;
    bus.Y      = y;
    bus.valid  = v;
    bus.ack    = a;
    model_step(r, req, y, v, a);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cycle(1'b1, 4'b1111, 2'b00, 1'b0, 1'b0);
    cycle(1'b1, 4'b1111, 2'b00, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 4'b1111, 2'b00, 1'b0, 1'b0);
      total++;
      if (bus.pending !== 4'b0000 || bus.D !== 4'b0000 || bus.overflow !== 4'b0000 || bus.boost !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got pend=%b D=%b ovf=%b boost=%b want 0000/0000/0000/0",
                 k, bus.pending, bus.D, bus.overflow, bus.boost);
      end
    end
  endtask

  task automatic test_single();
    cycle(1'b1, 4'b0000, 2'b00, 1'b0, 1'b0);
    cycle(1'b0, 4'b0100, 2'b00, 1'b0, 1'b0);
    total++;
    if (bus.D !== 4'b0100) begin bad++; $display("FAIL single_rise got D=%b want 0100", bus.D); end
    cycle(1'b0, 4'b0000, 2'b00, 1'b0, 1'b0);
    total++;
    if (bus.D !== 4'b0100) begin bad++; $display("FAIL single_hold got D=%b want 0100", bus.D); end
    cycle(1'b0, 4'b0000, 2'b01, 1'b1, 1'b1);
    total++;
    if (bus.D !== 4'b0000) begin bad++; $display("FAIL single_ack got D=%b want 0000", bus.D); end
  endtask

  task automatic test_concurrent();
    cycle(1'b0, 4'b1010, 2'b00, 1'b0, 1'b0);
    total++;
    if (bus.D !== 4'b1010) begin bad++; $display("FAIL conc_rise got D=%b want 1010", bus.D); end
    cycle(1'b0, 4'b0000, 2'b00, 1'b1, 1'b1);
    total++;
    if (bus.D !== 4'b0010) begin bad++; $display("FAIL conc_ack3 got D=%b want 0010", bus.D); end
    cycle(1'b0, 4'b0000, 2'b10, 1'b1, 1'b1);
    total++;
    if (bus.D !== 4'b0000) begin bad++; $display("FAIL conc_ack1 got D=%b want 0000", bus.D); end
  endtask

  task automatic test_overflow();
    cycle(1'b1, 4'b0000, 2'b00, 1'b0, 1'b0);
    cycle(1'b0, 4'b0010, 2'b00, 1'b0, 1'b0);
    cycle(1'b0, 4'b0000, 2'b00, 1'b0, 1'b0);
    cycle(1'b0, 4'b0010, 2'b00, 1'b0, 1'b0);
    total++;
    if (bus.overflow !== 4'b0010 || bus.pending !== 4'b0010) begin
      bad++;
      $display("FAIL ovf_dup got ovf=%b pend=%b want 0010/0010", bus.overflow, bus.pending);
    end
    cycle(1'b1, 4'b0000, 2'b00, 1'b0, 1'b0);
    cycle(1'b0, 4'b0010, 2'b00, 1'b0, 1'b0);
    cycle(1'b0, 4'b0000, 2'b00, 1'b0, 1'b0);
    cycle(1'b0, 4'b0010, 2'b10, 1'b1, 1'b1);
    total++;
    if (bus.overflow !== 4'b0000 || bus.pending !== 4'b0010) begin
      bad++;
      $display("FAIL ovf_collide got ovf=%b pend=%b want 0000/0010", bus.overflow, bus.pending);
    end
  endtask

  task automatic test_stale_ack();
    cycle(1'b0, 4'b0000, 2'b10, 1'b0, 1'b1);
    total++;
    if (bus.pending !== 4'b0010) begin bad++; $display("FAIL ack_novalid got pend=%b want 0010", bus.pending); end
    cycle(1'b0, 4'b0000, 2'b11, 1'b1, 1'b1);
    total++;
    if (bus.pending !== 4'b0010) begin bad++; $display("FAIL ack_notpend got pend=%b want 0010", bus.pending); end
  endtask

  task automatic test_aging();
    bit [3:0] exp_d;
    bit       exp_b;
    cycle(1'b1, 4'b0000, 2'b00, 1'b0, 1'b0);
    cycle(1'b0, 4'b1001, 2'b00, 1'b0, 1'b0);
    // Bit 3 keeps getting granted and re-requested together, so only bit 0 grows old.
    for (int k = 1; k <= 14; k++) begin
      if (k % 2 == 1) cycle(1'b0, 4'b0001, 2'b00, 1'b0, 1'b0);
      else            cycle(1'b0, 4'b1001, 2'b00, 1'b1, 1'b1);
    end
`ifdef PE_AGE_BOOST_EN
    exp_d = 4'b0001; exp_b = 1'b1;
`else
    exp_d = 4'b1001; exp_b = 1'b0;
`endif
    total++;
    if (bus.D !== exp_d || bus.boost !== exp_b) begin
      bad++;
      $display("FAIL age_sat got D=%b boost=%b want %b/%b", bus.D, bus.boost, exp_d, exp_b);
    end
    cycle(1'b0, 4'b0001, 2'b11, 1'b1, 1'b1);
    total++;
    if (bus.D !== 4'b1000 || bus.boost !== 1'b0) begin
      bad++;
      $display("FAIL age_release got D=%b boost=%b want 1000/0", bus.D, bus.boost);
    end
  endtask

  task automatic test_random();
    bit [3:0] req;
    bit [1:0] y;
    bit       v;
    bit       a;
    bit       r;
    int       errs;
    errs = 0;
    cycle(1'b1, 4'b0000, 2'b00, 1'b0, 1'b0);
    req = '0;
    for (int k = 0; k < 3000; k++) begin
      // Requests toggle sparsely so lines stay pending long enough to saturate.
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
      y = 2'($urandom_range(0, 3));
      v = ($urandom_range(0, 3) != 0);
      a = ($urandom_range(0, 4) == 0);
      r = ($urandom_range(0, 199) == 0);
      cycle(r, req, y, v, a);
      total++;
      if (bus.D !== m_D || bus.pending !== m_pend || bus.overflow !== m_ovf || bus.boost !== m_boost) begin
        bad++;
        if (errs < 10)
          $display("FAIL random cyc=%0d got D=%b pend=%b ovf=%b boost=%b want D=%b pend=%b ovf=%b boost=%b",
                   k, bus.D, bus.pending, bus.overflow, bus.boost, m_D, m_pend, m_ovf, m_boost);
        errs++;
      end
    end
  endtask

  initial begin
    bus.req_in = '0;
    bus.Y      = '0;
    bus.valid  = 1'b0;
    bus.ack    = 1'b0;
    m_prev     = '0;
    test_reset();
    test_single();
    test_concurrent();
    test_overflow();
    test_stale_ack();
    test_aging();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
